// File: rtl/maxpool2x2_stream_if.sv
// Streaming pixel bus for the 2x2 max-pool block: one pixel in per valid
// cycle, one pooled result out per valid_out pulse.
interface maxpool2x2_stream_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  frame_done;

  // Upstream pixel source / result sink
  modport master (
    output data_in,
    output valid_in,
    input  data_out,
    input  valid_out,
    input  frame_done
  );

  // Pooling engine
  modport slave (
    input  data_in,
    input  valid_in,
    output data_out,
    output valid_out,
    output frame_done
  );
endinterface

// File: rtl/maxpool2x2_stream.sv
// 2x2, stride-2 max pooling over a raster-ordered FP32 feature map.
// Even-column pixels park in a hold register, even rows fold their pairs
// into a half-width line buffer, and odd rows close each window and emit
// the result one cycle after the window's last pixel.
module maxpool2x2_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_SIZE   = 104
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  maxpool2x2_stream_if.slave  pool_if
);

  localparam int CW   = $clog2(IMG_SIZE);
  localparam int HALF = IMG_SIZE / 2;
  localparam int LW   = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CW-1:0]         colCnt_q, colCnt_d;
  logic [CW-1:0]         rowCnt_q, rowCnt_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] dataOut_q, dataOut_d;
  logic                  validOut_q, validOut_d;
  logic                  frameDone_q, frameDone_d;

  logic [DATA_WIDTH-1:0] lineBuf [HALF];
  logic                  lbWrEn;
  logic [LW-1:0]         lbIdx;
  logic [DATA_WIDTH-1:0] pairMax;
  logic                  lastCol;
  logic                  lastRow;

  // FP32 ordering on raw bits: positive beats negative, positives grow with
  // magnitude, negatives shrink with magnitude. +0 beats -0 via the sign rule.
  function automatic logic [DATA_WIDTH-1:0] fpMax(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic [DATA_WIDTH-1:0] res;
    if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) begin
      res = a[DATA_WIDTH-1] ? b : a;
    end else if (!a[DATA_WIDTH-1]) begin
      res = (a[DATA_WIDTH-2:0] >= b[DATA_WIDTH-2:0]) ? a : b;
    end else begin
      res = (a[DATA_WIDTH-2:0] <= b[DATA_WIDTH-2:0]) ? a : b;
    end
    return res;
  endfunction

  assign lastCol = (colCnt_q == CW'(IMG_SIZE - 1));
  assign lastRow = (rowCnt_q == CW'(IMG_SIZE - 1));
  assign lbIdx   = LW'(colCnt_q >> 1);
  assign pairMax = fpMax(hold_q, pool_if.data_in);

  // Next-state: raster position, hold capture, line-buffer fold and output
  always_comb begin
    colCnt_d    = colCnt_q;
    rowCnt_d    = rowCnt_q;
    hold_d      = hold_q;
    dataOut_d   = dataOut_q;
    validOut_d  = 1'b0;
    frameDone_d = 1'b0;
    lbWrEn      = 1'b0;

    if (pool_if.valid_in) begin
      if (!colCnt_q[0]) begin
        hold_d = pool_if.data_in;
      end else if (!rowCnt_q[0]) begin
        lbWrEn = 1'b1;
      end else begin
        dataOut_d   = fpMax(lineBuf[lbIdx], pairMax);
        validOut_d  = 1'b1;
        frameDone_d = lastCol && lastRow;
      end

      if (lastCol) begin
        colCnt_d = '0;
        rowCnt_d = lastRow ? '0 : rowCnt_q + CW'(1);
      end else begin
        colCnt_d = colCnt_q + CW'(1);
      end
    end
  end

  // State and output registers, cleared asynchronously so an aborted frame leaves no trace
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      colCnt_q    <= '0;
      rowCnt_q    <= '0;
      hold_q      <= '0;
      dataOut_q   <= '0;
      validOut_q  <= 1'b0;
      frameDone_q <= 1'b0;
    end else begin
      colCnt_q    <= colCnt_d;
      rowCnt_q    <= rowCnt_d;
      hold_q      <= hold_d;
      dataOut_q   <= dataOut_d;
      validOut_q  <= validOut_d;
      frameDone_q <= frameDone_d;
    end
  end

  // Line buffer: every entry is written on an even row before the odd row reads it
  always_ff @(posedge clk_i) begin
    if (lbWrEn) begin
      lineBuf[lbIdx] <= pairMax;
    end
  end

  assign pool_if.data_out   = dataOut_q;
  assign pool_if.valid_out  = validOut_q;
  assign pool_if.frame_done = frameDone_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Self-checking bench: a 4x4 instance for directed and random windows, and a
// 104x104 instance for two back-to-back random frames. The reference keeps
// the whole frame and pools each 2x2 window with a monotonic integer key.
module tb_maxpool2x2_stream;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic        drvValid;
  logic [31:0] drvData;

  logic        obsValid;
  logic [31:0] obsData;
  logic        obsDone;

  int compareCount;
  int mismatchCount;
  int doneSeen;
  int outCount;

  int          mRow;
  int          mCol;
  int          mN;
  logic [31:0] mPix [0:104*104-1];
  logic [31:0] lastExp [2];
  logic [31:0] outQ [$];
  logic [31:0] prevPix;

  logic [31:0] ramp [16] = '{
    32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
    32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
    32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
    32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000
  };
  logic [31:0] rampExp [4] = '{32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000};

  maxpool2x2_stream_if #(.DATA_WIDTH(32)) bus4 ();
  maxpool2x2_stream_if #(.DATA_WIDTH(32)) bus104 ();

  maxpool2x2_stream #(.DATA_WIDTH(32), .IMG_SIZE(4)) u_pool4 (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .pool_if (bus4.slave)
  );

  maxpool2x2_stream #(.DATA_WIDTH(32), .IMG_SIZE(104)) u_pool104 (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .pool_if (bus104.slave)
  );

  assign bus4.valid_in   = drvValid && !sel;
  assign bus4.data_in    = drvData;
  assign bus104.valid_in = drvValid && sel;
  assign bus104.data_in  = drvData;

  assign obsValid = sel ? bus104.valid_out  : bus4.valid_out;
  assign obsData  = sel ? bus104.data_out   : bus4.data_out;
  assign obsDone  = sel ? bus104.frame_done : bus4.frame_done;

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Larger key means larger FP32 under the bit-ordering rule; -0 sorts just below +0
  function automatic logic [31:0] orderKey(input logic [31:0] x);
    return x[31] ? ~x : {1'b1, x[30:0]};
  endfunction

  function automatic logic [31:0] refMax4(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c, input logic [31:0] d);
    logic [31:0] v [4];
    logic [31:0] best;
    v = '{a, b, c, d};
    best = v[0];
    for (int i = 1; i < 4; i++) begin
      if (orderKey(v[i]) > orderKey(best)) best = v[i];
    end
    return best;
  endfunction

  // Mix of plain random words, signed zeros, infinities, NaNs and repeats
  function automatic logic [31:0] randPix(input logic [31:0] prev);
    logic [31:0] r;
    case ($urandom_range(0, 9))
      0:       r = 32'h00000000;
      1:       r = 32'h80000000;
      2:       r = ($urandom_range(0, 1) != 0) ? 32'h7F800000 : 32'hFF800000;
      3:       r = 32'h7FC00000 | ($urandom & 32'h803FFFFF);
      4:       r = prev;
      5:       r = prev ^ 32'h80000000;
      default: r = $urandom;
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compareCount++;
    if (got !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one cycle from a negedge, then check the registered result at the next negedge
  task automatic applyStimulus(input logic v, input logic [31:0] d);
    logic        expValid;
    logic        expDone;
    int          idx;
    int          s;
    s        = sel ? 1 : 0;
    expValid = 1'b0;
    expDone  = 1'b0;
    drvValid = v;
    drvData  = d;
    if (v) begin
      idx = mRow * mN + mCol;
      mPix[idx] = d;
      if ((mRow % 2 == 1) && (mCol % 2 == 1)) begin
        expValid   = 1'b1;
        expDone    = (mRow == mN - 1) && (mCol == mN - 1);
        lastExp[s] = refMax4(mPix[idx - mN - 1], mPix[idx - mN], mPix[idx - 1], mPix[idx]);
      end
      mCol++;
      if (mCol == mN) begin
        mCol = 0;
        mRow = (mRow == mN - 1) ? 0 : mRow + 1;
      end
    end
    @(negedge clk);
    drvValid = 1'b0;
    checkOutput("valid_out", {31'b0, obsValid}, {31'b0, expValid});
    checkOutput("data_out", obsData, lastExp[s]);
    checkOutput("frame_done", {31'b0, obsDone}, {31'b0, expDone});
    if (obsValid) begin
      outQ.push_back(obsData);
      outCount++;
    end
    if (obsDone) doneSeen++;
  endtask

  // Hold reset for a few cycles, checking both instances go quiet asynchronously
  task automatic resetDut(input int cycles);
    @(negedge clk);
    drvValid = 1'b0;
    rst_n    = 1'b0;
    for (int i = 0; i <= cycles; i++) begin
      if (i == 0) #1;
      else @(negedge clk);
      checkOutput("rst_data4", bus4.data_out, 32'h0);
      checkOutput("rst_valid4", {31'b0, bus4.valid_out}, 32'h0);
      checkOutput("rst_done4", {31'b0, bus4.frame_done}, 32'h0);
      checkOutput("rst_data104", bus104.data_out, 32'h0);
      checkOutput("rst_valid104", {31'b0, bus104.valid_out}, 32'h0);
    end
    @(negedge clk);
    rst_n      = 1'b1;
    mRow       = 0;
    mCol       = 0;
    lastExp[0] = '0;
    lastExp[1] = '0;
  endtask

  task automatic checkRampOutputs(input string tag);
    checkOutput({tag, "_count"}, outQ.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput(tag, (i < outQ.size()) ? outQ[i] : 32'hDEADBEEF, rampExp[i]);
    end
  endtask

  // Main sequence
  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    doneSeen      = 0;
    outCount      = 0;
    rst_n         = 1'b0;
    sel           = 1'b0;
    drvValid      = 1'b0;
    drvData       = '0;
    mN            = 4;
    prevPix       = 32'h3F800000;

    resetDut(2);

    // Ramp 1.0..16.0 with continuous valid
    $display("[TB] ramp frame, continuous valid");
    outQ.delete();
    doneSeen = 0;
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, ramp[i]);
    applyStimulus(1'b0, $urandom);
    checkRampOutputs("ramp_cont");
    checkOutput("ramp_cont_done", doneSeen, 32'd1);

    // Same ramp with a bubble after every pixel
    $display("[TB] ramp frame, valid every other cycle");
    outQ.delete();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, ramp[i]);
      applyStimulus(1'b0, $urandom);
    end
    checkRampOutputs("ramp_gap");

    // All-negative top-left window
    $display("[TB] negative window");
    outQ.delete();
    for (int i = 0; i < 16; i++) begin
      case (i)
        0:       applyStimulus(1'b1, 32'hBF800000);
        1:       applyStimulus(1'b1, 32'hC0000000);
        4:       applyStimulus(1'b1, 32'hBF000000);
        5:       applyStimulus(1'b1, 32'hC0400000);
        default: applyStimulus(1'b1, $urandom);
      endcase
    end
    checkOutput("neg_window", (outQ.size() > 0) ? outQ[0] : 32'hDEADBEEF, 32'hBF000000);

    // Signed-zero window
    $display("[TB] signed zero window");
    outQ.delete();
    for (int i = 0; i < 16; i++) begin
      case (i)
        0, 4, 5: applyStimulus(1'b1, 32'h80000000);
        1:       applyStimulus(1'b1, 32'h00000000);
        default: applyStimulus(1'b1, $urandom);
      endcase
    end
    checkOutput("zero_window", (outQ.size() > 0) ? outQ[0] : 32'hDEADBEEF, 32'h00000000);

    // Abort a frame after six pixels, then a clean ramp
    $display("[TB] mid-frame reset");
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, $urandom);
    resetDut(2);
    outQ.delete();
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, ramp[i]);
    applyStimulus(1'b0, $urandom);
    applyStimulus(1'b0, $urandom);
    checkRampOutputs("post_reset");

    // Random 4x4 frames with random bubbles, back-to-back
    $display("[TB] random 4x4 frames");
    for (int f = 0; f < 8; f++) begin
      for (int p = 0; p < 16; p++) begin
        while ($urandom_range(0, 3) == 0) applyStimulus(1'b0, $urandom);
        prevPix = randPix(prevPix);
        applyStimulus(1'b1, prevPix);
      end
    end

    // Two back-to-back 104x104 frames, no gaps
    $display("[TB] two 104x104 frames");
    applyStimulus(1'b0, $urandom);
    sel      = 1'b1;
    mN       = 104;
    doneSeen = 0;
    outCount = 0;
    for (int p = 0; p < 2 * 104 * 104; p++) begin
      prevPix = randPix(prevPix);
      applyStimulus(1'b1, prevPix);
    end
    applyStimulus(1'b0, $urandom);
    checkOutput("big_outputs", outCount, 32'd5408);
    checkOutput("big_frame_done", doneSeen, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/maxpool2x2_stream.md
MAXPOOL2X2_STREAM -- requirements
Module: maxpool2x2_stream

Interface
REQ-001 Parameter DATA_WIDTH, default 32, IEEE-754 single-precision sample width.
REQ-002 Parameter IMG_SIZE, default 104, input feature-map width = height in pixels; SHALL be even and >= 2.
REQ-003 Clk  input  1  single clock; all state changes on rising edge.
REQ-004 Rst  input  1  asynchronous, active-low reset.
REQ-005 data_in  input  DATA_WIDTH  FP32 pixel of one feature map, raster order (row-major, column 0 first).
REQ-006 valid_in  input  1  data_in qualifier, one pixel per high cycle; no backpressure.
REQ-007 data_out  output  DATA_WIDTH  FP32 max of one 2x2 window.
REQ-008 valid_out  output  1  data_out qualifier, one-cycle pulse per result.
REQ-009 frame_done  output  1  one-cycle pulse coincident with the last valid_out of a frame.

Function
REQ-010 Block SHALL perform 2x2, stride-2 max pooling on the upstream channel-summed feature map: IMG_SIZE x IMG_SIZE in, (IMG_SIZE/2)^2 out per frame.
REQ-011 Column counter (0..IMG_SIZE-1) and row counter (0..IMG_SIZE-1) SHALL advance only on valid_in=1; column wraps to 0 and increments row; row wraps to 0 after the last pixel.
REQ-012 Idle cycles (valid_in=0) SHALL hold all state and produce valid_out=0.
REQ-013 Even column, any row: pixel SHALL be captured into a hold register.
REQ-014 Even row, odd column: max(hold, data_in) SHALL be written to line buffer entry col>>1 (depth IMG_SIZE/2, width DATA_WIDTH).
REQ-015 Odd row, odd column: max(linebuf[col>>1], hold, data_in) SHALL be registered to data_out with valid_out=1 on the next rising edge (latency 1 cycle).
REQ-016 Outside REQ-015 cycles, valid_out SHALL be 0; data_out SHALL hold its last value.
REQ-017 frame_done SHALL assert with the output produced by pixel (IMG_SIZE-1, IMG_SIZE-1).
REQ-018 Comparison SHALL be FP32 ordering without arithmetic: signs differ -> sign=0 operand larger; both positive -> larger unsigned [30:0] larger; both negative -> smaller unsigned [30:0] larger.
REQ-019 Ties (identical bits) SHALL select either operand (bit-identical result); +0 vs -0 SHALL yield +0 (0x00000000).
REQ-020 NaN/Inf SHALL receive no special handling; they are ordered by the REQ-018 bit rule.
REQ-021 Back-to-back frames SHALL be supported with no gap cycles between the last pixel of one frame and the first of the next.
REQ-022 Line buffer SHALL be written before being read in every frame, so its contents need no reset.

Reset
REQ-023 While Rst=0: row/col counters=0, hold=0, data_out=0, valid_out=0, frame_done=0, asynchronously.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame; the first valid_in after release is pixel (0,0) and no output from the aborted frame SHALL appear.

Verification (IMG_SIZE=4 unless stated)
REQ-025 Pixels 1.0..16.0 raster, valid_in continuous -> valid_out after pixels 6, 8, 14, 16 (+1 cycle): 0x40C00000, 0x41000000, 0x41600000, 0x41800000; frame_done with last.
REQ-026 Window {-1.0, -2.0, -0.5, -3.0} (0xBF800000, 0xC0000000, 0xBF000000, 0xC0400000) in top-left -> first output 0xBF000000.
REQ-027 Window {0x80000000, 0x00000000, 0x80000000, 0x80000000} -> output 0x00000000.
REQ-028 Stimulus of REQ-025 with valid_in high every other cycle -> same four values, each one cycle after its closing pixel; no extra valid_out.
REQ-029 6 pixels, Rst low 2 cycles, then REQ-025 stimulus -> exactly the REQ-025 four outputs, outputs 0 during reset.
REQ-030 IMG_SIZE=104, two back-to-back frames of random FP32 -> 2704 outputs per frame matching a reference model, frame_done pulses exactly twice.
